// File: rtl/prod_pkg.sv
// Shared types and constants for the product stock controller and its counters.
package prod_pkg;

  localparam int PROD_CNT_W     = 4;
  localparam int MAX_STOCK_DEF  = 15;
  localparam int LOW_THRESH_DEF = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CHECK    = 2'd1,
    DISPENSE = 2'd2,
    DONE     = 2'd3
  } prod_state_e;

endpackage

// File: rtl/prod_stock_ctr.sv
// One saturating 4-bit stock counter; reset loads INIT_STOCK.
// A simultaneous inc and dec cancel out, so the count is left unchanged.
module prod_stock_ctr
  import prod_pkg::*;
#(
  parameter int MAX_STOCK  = MAX_STOCK_DEF,
  parameter int INIT_STOCK = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  input  logic                  dec,
  output logic [PROD_CNT_W-1:0] count
);

  localparam logic [PROD_CNT_W-1:0] MAX_V  = PROD_CNT_W'(MAX_STOCK);
  localparam logic [PROD_CNT_W-1:0] INIT_V = PROD_CNT_W'(INIT_STOCK);

  logic [PROD_CNT_W-1:0] count_reg;
  logic [PROD_CNT_W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (inc && !dec) begin
      if (count_reg < MAX_V) count_next = count_reg + 1'b1;
    end else if (dec && !inc) begin
      if (count_reg != '0) count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_reg <= INIT_V;
    else      count_reg <= count_next;
  end

  assign count = count_reg;

endmodule

// File: rtl/prod_stock_ctrl.sv
// Vending-machine inventory controller: per-product stock counters, four-phase dispense
// handshake and motor pulse. Optional low-stock flag enabled by PROD_STOCK_LOW_WARN_EN.
module prod_stock_ctrl
  import prod_pkg::*;
#(
  parameter int NUM_PROD    = 4,
  parameter int MAX_STOCK   = MAX_STOCK_DEF,
  parameter int INIT_STOCK  = 9,
  parameter int DISP_CYCLES = 4,
  parameter int LOW_THRESH  = LOW_THRESH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [$clog2(NUM_PROD)-1:0] sel,
  input  logic                        disp_req,
  output logic                        disp_ack,
  output logic                        disp_ok,
  output logic                        motor,
  input  logic                        restock,
  output logic                        busy,
  output logic [PROD_CNT_W-1:0]       prod_count_current,
  output logic                        stock_low
);

  localparam int SEL_W = $clog2(NUM_PROD);
  localparam int CYC_W = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;
  localparam logic [CYC_W-1:0]      CYC_LOAD = CYC_W'(DISP_CYCLES - 1);
  localparam logic [PROD_CNT_W-1:0] INIT_V   = PROD_CNT_W'(INIT_STOCK);

  if (NUM_PROD < 2 || MAX_STOCK > 15 || INIT_STOCK > MAX_STOCK ||
      DISP_CYCLES < 1 || LOW_THRESH > 15) begin : g_param_check
    $error("prod_stock_ctrl: illegal parameter combination");
  end

  prod_state_e           state_reg, state_next;
  logic [CYC_W-1:0]      cyc_reg, cyc_next;
  logic [SEL_W-1:0]      psel_reg, psel_next;
  logic                  disp_ok_reg, disp_ok_next;
  logic                  disp_ack_reg, motor_reg, busy_reg;
  logic [PROD_CNT_W-1:0] pcc_reg;
  logic                  dec_fire;
  logic [PROD_CNT_W-1:0] count [NUM_PROD];

  genvar gi;
  for (gi = 0; gi < NUM_PROD; gi++) begin : g_ctr
    prod_stock_ctr #(
      .MAX_STOCK (MAX_STOCK),
      .INIT_STOCK(INIT_STOCK)
    ) u_ctr (
      .clk  (clk),
      .rst  (rst),
      .inc  (restock && (sel == SEL_W'(gi))),
      .dec  (dec_fire && (psel_reg == SEL_W'(gi))),
      .count(count[gi])
    );
  end

  always_comb begin
    state_next   = state_reg;
    cyc_next     = cyc_reg;
    psel_next    = psel_reg;
    disp_ok_next = disp_ok_reg;
    dec_fire     = 1'b0;
    case (state_reg)
      IDLE: begin
        disp_ok_next = 1'b0;
        if (disp_req) begin
          psel_next  = sel;
          state_next = CHECK;
        end
      end
      CHECK: begin
        if (count[psel_reg] == '0) begin
          state_next   = DONE;
          disp_ok_next = 1'b0;
        end else begin
          state_next = DISPENSE;
          cyc_next   = CYC_LOAD;
        end
      end
      DISPENSE: begin
        if (cyc_reg == '0) begin
          state_next   = DONE;
          dec_fire     = 1'b1;
          disp_ok_next = 1'b1;
        end else begin
          cyc_next = cyc_reg - 1'b1;
        end
      end
      DONE: begin
        if (!disp_req) begin
          state_next   = IDLE;
          disp_ok_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      cyc_reg      <= '0;
      psel_reg     <= '0;
      disp_ok_reg  <= 1'b0;
      disp_ack_reg <= 1'b0;
      motor_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      pcc_reg      <= INIT_V;
    end else begin
      state_reg    <= state_next;
      cyc_reg      <= cyc_next;
      psel_reg     <= psel_next;
      disp_ok_reg  <= disp_ok_next;
      disp_ack_reg <= (state_next == DONE);
      motor_reg    <= (state_next == DISPENSE);
      busy_reg     <= (state_next != IDLE);
      pcc_reg      <= count[sel];
    end
  end

  assign disp_ack           = disp_ack_reg;
  assign disp_ok            = disp_ok_reg;
  assign motor              = motor_reg;
  assign busy               = busy_reg;
  assign prod_count_current = pcc_reg;

`ifdef PROD_STOCK_LOW_WARN_EN
  localparam logic [PROD_CNT_W-1:0] LOW_V = PROD_CNT_W'(LOW_THRESH);
  logic stock_low_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stock_low_reg <= 1'b0;
    else      stock_low_reg <= (count[sel] != '0) && (count[sel] <= LOW_V);
  end

  assign stock_low = stock_low_reg;
`else
  assign stock_low = 1'b0;
`endif

endmodule
